// File: rtl/mdu_param.sv
// Multiply/divide unit with a private HI/LO pair: MULT(U), DIV(U), MADD(U), MSUB(U), MTHI/MTLO.
// Latency: MUL_LAT cycles for multiply-class ops, DIV_LAT for divides; Done pulses the cycle results land.
// Backpressure: Busy is high while an op is in flight; Start during RUN (or alongside We) is dropped.
module mdu_param #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic             We,
  input  logic             HiLo,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW   = $clog2(MAXL + 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;

  // Datapath results, computed only from the operands captured at Start.
  logic [2*WIDTH-1:0]   ext_a, ext_b, prod, mres;
  logic                 mul_sgn, div_sgn, a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag, uquo, urem, quo, rem;

  // Multiply: sign-extend to 2*WIDTH so one truncated product serves both signednesses.
  always_comb begin
    mul_sgn = op_q[0];
    ext_a   = {{WIDTH{mul_sgn & a_q[WIDTH-1]}}, a_q};
    ext_b   = {{WIDTH{mul_sgn & b_q[WIDTH-1]}}, b_q};
    prod    = ext_a * ext_b;
    case (op_q[2:1])
      2'b10:   mres = acc_q + prod;
      2'b11:   mres = acc_q - prod;
      default: mres = prod;
    endcase
  end

  // Divide on magnitudes, then restore signs. The most-negative / -1 case falls out
  // naturally: its magnitude negates back to most-negative with a zero remainder.
  always_comb begin
    div_sgn = op_q[0];
    a_neg   = div_sgn & a_q[WIDTH-1];
    b_neg   = div_sgn & b_q[WIDTH-1];
    a_mag   = a_neg ? -a_q : a_q;
    b_mag   = b_neg ? -b_q : b_q;
    if (b_mag != '0) begin
      uquo = a_mag / b_mag;
      urem = a_mag % b_mag;
    end else begin
      uquo = '0;
      urem = '0;
    end
    quo = (a_neg ^ b_neg) ? -uquo : uquo;
    rem = a_neg ? -urem : urem;
  end

  // Next-state: We writes first, Start launches from IDLE, completion overrides We in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    if (We) begin
      if (HiLo) hi_d = D1;
      else      lo_d = D1;
    end

    case (state_q)
      ST_IDLE: begin
        if (Start && !We) begin
          op_d    = Op;
          a_d     = D1;
          b_d     = D2;
          acc_d   = Op[2] ? {hi_q, lo_q} : acc_q;
          cnt_d   = (Op[2:1] == 2'b01) ? CW'(DIV_LAT) : CW'(MUL_LAT);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          if (op_q[2:1] == 2'b01) begin
            // Divide by zero leaves HI/LO untouched.
            if (b_q != '0) begin
              hi_d = rem;
              lo_d = quo;
            end
          end else begin
            {hi_d, lo_d} = mres;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous reset; reset discards any in-flight op.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign Busy = (state_q == ST_RUN);
  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_param.sv
// Bench for mdu_param: a 32-bit instance (5/10 latency) and an 8-bit instance (1/3 latency).
// Latency: checks Busy length, single Done pulse and HI/LO against hand-computed values.
// Backpressure: exercises Start during RUN, We during RUN, We+Start in IDLE, reset mid-op.
module tb_mdu_param;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start, We, HiLo, Busy, Done;
  logic [2:0]  Op;
  logic [31:0] D1, D2, HI, LO;

  logic        Start2, We2, HiLo2, Busy2, Done2;
  logic [2:0]  Op2;
  logic [7:0]  D1b, D2b, HI2, LO2;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  mdu_param #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .D1(D1), .D2(D2),
    .We(We), .HiLo(HiLo), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  mdu_param #(.WIDTH(8), .MUL_LAT(1), .DIV_LAT(3)) dut8 (
    .Clk(Clk), .Rst(Rst), .Start(Start2), .Op(Op2), .D1(D1b), .D2(D2b),
    .We(We2), .HiLo(HiLo2), .Busy(Busy2), .Done(Done2), .HI(HI2), .LO(LO2)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Launch one op, count Busy cycles, verify HI/LO hold while busy, then check the result.
  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] eh, input logic [31:0] el);
    int          bc;
    int          ds;
    int          held;
    logic [31:0] ph, pl;
    @(negedge Clk);
    ph = HI; pl = LO;
    Start = 1'b1; Op = op; D1 = a; D2 = b;
    @(negedge Clk);
    Start = 1'b0; Op = 3'($urandom); D1 = $urandom; D2 = $urandom;
    bc = 0; ds = 0; held = 1;
    for (int c = 0; c < 64 && ds == 0; c++) begin
      if (Done) ds = 1;
      else begin
        if (Busy) bc++;
        if (HI !== ph || LO !== pl) held = 0;
        @(negedge Clk);
      end
    end
    chk({nm, " done"}, 64'(ds), 64'd1);
    chk({nm, " busy_cycles"}, 64'(bc), 64'(lat));
    chk({nm, " hold"}, 64'(held), 64'd1);
    chk({nm, " busy_at_done"}, 64'(Busy), 64'd0);
    chk({nm, " hi:lo"}, {HI, LO}, {eh, el});
    @(negedge Clk);
    chk({nm, " done_pulse"}, 64'(Done), 64'd0);
  endtask

  vec_t vecs[$];

  initial begin
    int ds;
    int dcnt;

    vecs.push_back('{"multu",  3'b000, 32'hFFFFFFFF, 32'h2,        5,  32'h1,        32'hFFFFFFFE});
    vecs.push_back('{"mult",   3'b001, 32'hFFFFFFFD, 32'h7,        5,  32'hFFFFFFFF, 32'hFFFFFFEB});
    vecs.push_back('{"madd",   3'b101, 32'h2,        32'h5,        5,  32'hFFFFFFFF, 32'hFFFFFFF5});
    vecs.push_back('{"msub",   3'b111, 32'h3,        32'h4,        5,  32'hFFFFFFFF, 32'hFFFFFFE9});
    vecs.push_back('{"msubu",  3'b110, 32'hFFFFFFFF, 32'h2,        5,  32'hFFFFFFFD, 32'hFFFFFFEB});
    vecs.push_back('{"maddu",  3'b100, 32'h10,       32'h2,        5,  32'hFFFFFFFE, 32'h0000000B});
    vecs.push_back('{"mult_m1",3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'h0,        32'h1});
    vecs.push_back('{"multu_m",3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h1});
    vecs.push_back('{"div_n7", 3'b011, 32'hFFFFFFF9, 32'h2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{"div_7n2",3'b011, 32'h7,        32'hFFFFFFFE, 10, 32'h1,        32'hFFFFFFFD});
    vecs.push_back('{"div_ovf",3'b011, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0,        32'h80000000});
    vecs.push_back('{"divu",   3'b010, 32'd100,      32'd7,        10, 32'd2,        32'd14});
    vecs.push_back('{"divu_b", 3'b010, 32'hFFFFFFFF, 32'h2,        10, 32'h1,        32'h7FFFFFFF});
    vecs.push_back('{"div_m1", 3'b011, 32'hFFFFFFFF, 32'h2,        10, 32'hFFFFFFFF, 32'h0});

    Rst = 1'b1; Start = 0; We = 0; HiLo = 0; Op = 0; D1 = 0; D2 = 0;
    Start2 = 0; We2 = 0; HiLo2 = 0; Op2 = 0; D1b = 0; D2b = 0;
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    chk("reset busy", 64'(Busy), 64'd0);
    chk("reset done", 64'(Done), 64'd0);
    chk("reset hi:lo", {HI, LO}, 64'd0);
    chk("reset8 hi:lo:busy", {47'd0, Busy2, HI2, LO2}, 64'd0);

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat,
             vecs[i].exp_hi, vecs[i].exp_lo);

    // Preload through We, then divide by zero: HI/LO keep the preloaded values.
    @(negedge Clk); We = 1; HiLo = 1; D1 = 32'h1234;
    @(negedge Clk); HiLo = 0; D1 = 32'h5678;
    @(negedge Clk); We = 0;
    chk("we preload", {HI, LO}, {32'h1234, 32'h5678});
    run_op("divu_by0", 3'b010, 32'd99, 32'd0, 10, 32'h1234, 32'h5678);
    run_op("div_by0",  3'b011, 32'hFFFFFF00, 32'd0, 10, 32'h1234, 32'h5678);

    // We together with Start in IDLE: the write lands, the Start is dropped.
    @(negedge Clk); We = 1; HiLo = 0; D1 = 32'h55; Start = 1; Op = 3'b000; D2 = 32'd3;
    @(negedge Clk); We = 0; Start = 0;
    chk("we+start busy", 64'(Busy), 64'd0);
    chk("we+start lo", 64'(LO), 64'h55);

    // MULTU 3x4 with a We at cycle 2 and an ignored Start at cycle 3.
    @(negedge Clk); Start = 1; Op = 3'b000; D1 = 32'd3; D2 = 32'd4;
    @(negedge Clk); Start = 0;
    @(negedge Clk); We = 1; HiLo = 0; D1 = 32'hAA;
    @(negedge Clk); We = 0; Start = 1; Op = 3'b000; D1 = 32'd9; D2 = 32'd9;
    chk("run we lo", 64'(LO), 64'hAA);
    @(negedge Clk); Start = 0;
    chk("run we busy", 64'(Busy), 64'd1);
    ds = 0;
    for (int c = 0; c < 32 && ds == 0; c++) begin
      if (Done) ds = 1;
      else @(negedge Clk);
    end
    chk("run we done", 64'(ds), 64'd1);
    chk("run we result", {HI, LO}, {32'd0, 32'd12});
    @(negedge Clk);
    chk("run we 2nd start ignored", 64'(Busy), 64'd0);

    // Reset on cycle 3 of a DIV: everything clears and Done never fires.
    @(negedge Clk); Start = 1; Op = 3'b011; D1 = 32'hFFFFFFF9; D2 = 32'd2;
    @(negedge Clk); Start = 0;
    @(negedge Clk);
    @(negedge Clk); Rst = 1;
    @(negedge Clk); Rst = 0;
    chk("rst mid hi:lo", {HI, LO}, 64'd0);
    chk("rst mid busy", 64'(Busy), 64'd0);
    dcnt = 0;
    for (int c = 0; c < 15; c++) begin
      if (Done) dcnt++;
      @(negedge Clk);
    end
    chk("rst mid no done", 64'(dcnt), 64'd0);

    // 8-bit instance, MUL_LAT=1: MULTU 0xFF*0xFF.
    @(negedge Clk); Start2 = 1; Op2 = 3'b000; D1b = 8'hFF; D2b = 8'hFF;
    @(negedge Clk); Start2 = 0; D1b = 8'h00; D2b = 8'h00;
    chk("w8 busy", 64'(Busy2), 64'd1);
    chk("w8 hold", {HI2, LO2}, 16'h0000);
    @(negedge Clk);
    chk("w8 done", {Busy2, Done2}, 2'b01);
    chk("w8 multu", {HI2, LO2}, 16'hFE01);
    @(negedge Clk);
    chk("w8 done_pulse", 64'(Done2), 64'd0);

    // 8-bit DIV -7/2 with DIV_LAT=3.
    @(negedge Clk); Start2 = 1; Op2 = 3'b011; D1b = 8'hF9; D2b = 8'h02;
    @(negedge Clk); Start2 = 0;
    @(negedge Clk);
    @(negedge Clk);
    chk("w8 div busy", 64'(Busy2), 64'd1);
    @(negedge Clk);
    chk("w8 div done", {Busy2, Done2}, 2'b01);
    chk("w8 div", {HI2, LO2}, 16'hFFFD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
